// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts an op from execute, issues one word-wide memory
// request over req/ack, and returns the extended load data with a one-cycle done pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshakes: an op transfers on a rising edge where lsu_valid & lsu_ready are both
  // high; a memory request transfers on a rising edge where mem_req & mem_ack are both
  // high, and mem_req with every mem_* field stays constant until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] timer;

  logic        acc_illegal;
  logic        acc_misaligned;
  logic [3:0]  acc_strb;
  logic [31:0] acc_wdata;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  assign lsu_ready = (state == IDLE) && !reset;
  assign state_dbg = state;

  // Decode of the op presented at the input, used only on the accept edge.
  always_comb begin
    acc_illegal    = 1'b0;
    acc_misaligned = 1'b0;
    acc_strb       = 4'b0000;
    acc_wdata      = lsu_wdata;
    if (lsu_we) begin
      acc_illegal = (lsu_funct3 > 3'b010);
    end else begin
      acc_illegal = (lsu_funct3 == 3'b011) || (lsu_funct3 == 3'b110) ||
                    (lsu_funct3 == 3'b111);
    end
    if (lsu_funct3[1:0] == 2'b01) begin
      acc_misaligned = lsu_addr[0];
    end else if (lsu_funct3[1:0] == 2'b10) begin
      acc_misaligned = (lsu_addr[1:0] != 2'b00);
    end
    if (lsu_we) begin
      case (lsu_funct3)
        3'b000: begin
          acc_strb  = 4'b0001 << lsu_addr[1:0];
          acc_wdata = {4{lsu_wdata[7:0]}};
        end
        3'b001: begin
          acc_strb  = 4'b0011 << lsu_addr[1:0];
          acc_wdata = {2{lsu_wdata[15:0]}};
        end
        3'b010: begin
          acc_strb  = 4'b1111;
          acc_wdata = lsu_wdata;
        end
        default: begin
          acc_strb  = 4'b0000;
          acc_wdata = lsu_wdata;
        end
      endcase
    end
  end

  // Align the addressed byte/half to bit 0, then extend according to funct3.
  always_comb begin
    load_shifted = mem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = {24'd0, load_shifted[7:0]};
      3'b101:  load_ext = {16'd0, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      timer     <= 32'd0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            we_q      <= lsu_we;
            funct3_q  <= lsu_funct3;
            addr_lo_q <= lsu_addr[1:0];
            if (acc_illegal || acc_misaligned) begin
              state    <= DONE;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
            end else begin
              state     <= REQ;
              timer     <= 32'd1;
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem_wstrb <= acc_strb;
              mem_wdata <= acc_wdata;
            end
          end
        end
        REQ: begin
          // An ack in the final timeout cycle still completes the op cleanly.
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            lsu_done <= 1'b1;
            lsu_err  <= 1'b0;
            if (!we_q) begin
              lsu_rdata <= load_ext;
            end
          end else if ((TIMEOUT != 0) && (timer == TIMEOUT)) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            lsu_done <= 1'b1;
            lsu_err  <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          timer <= 32'd0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single ops with a scripted
// memory responder, plus hand sequences for reset, mid-op reset and back-to-back ops.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    int          reqs;
    int          lat;
    logic [3:0]  strb;
    logic [31:0] mwdata;
    logic [31:0] rdata_exp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                     input logic err, input int reqs, input int lat, input logic [3:0] strb,
                     input logic [31:0] mwdata, input logic [31:0] rdata_exp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.delay = delay; v.err = err; v.reqs = reqs; v.lat = lat; v.strb = strb;
    v.mwdata = mwdata; v.rdata_exp = rdata_exp;
    vq.push_back(v);
  endtask

  // driver + memory responder for one op; lat counts negedges after the accept edge
  task automatic run_op(input vec_t v, input int idx);
    int reqs;
    int lat;
    logic [31:0] exp_maddr;
    string tag;
    reqs = 0;
    lat = 0;
    exp_maddr = {v.addr[31:2], 2'b00};
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, lsu_ready}, 32'd1);
    lsu_valid  = 1'b1;
    lsu_we     = v.we;
    lsu_funct3 = v.f3;
    lsu_addr   = v.addr;
    lsu_wdata  = v.wdata;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      lsu_valid = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (lsu_done) begin
        lat = cyc;
        break;
      end
      if (mem_req) begin
        reqs++;
        chk({tag, ".mem_addr"}, mem_addr, exp_maddr);
        chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.strb});
        chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
        if (v.we) chk({tag, ".mem_wdata"}, mem_wdata, v.mwdata);
        if (reqs - 1 == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
    end
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".reqs"}, reqs, v.reqs);
    chk({tag, ".err"}, {31'd0, lsu_err}, {31'd0, v.err});
    chk({tag, ".rdata"}, lsu_rdata, v.rdata_exp);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, lsu_done}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    //         we  f3      addr          wdata         rdata         dly err reqs lat strb     mwdata        rdata_exp
    add(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1, 2, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
    add(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 1'b0, 1, 2, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000);
    add(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0,        0, 1'b0, 1, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0000);
    add(1'b0, 3'b000, 32'h0000_0001, 32'h0,         32'h80F1_7F02, 3, 1'b0, 4, 5, 4'b0000, 32'h0,         32'h0000_007F);
    add(1'b0, 3'b000, 32'h0000_0003, 32'h0,         32'h80F1_7F02, 3, 1'b0, 4, 5, 4'b0000, 32'h0,         32'hFFFF_FF80);
    add(1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h80F1_7F02, 3, 1'b0, 4, 5, 4'b0000, 32'h0,         32'h0000_80F1);
    add(1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'h80F1_7F02, 3, 1'b0, 4, 5, 4'b0000, 32'h0,         32'hFFFF_80F1);
    add(1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,        0, 1'b1, 0, 1, 4'b0000, 32'h0,         32'hFFFF_80F1);
    add(1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        0, 1'b1, 0, 1, 4'b0000, 32'h0,         32'hFFFF_80F1);
    add(1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        0, 1'b1, 0, 1, 4'b0000, 32'h0,         32'hFFFF_80F1);
    add(1'b1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,        0, 1'b1, 0, 1, 4'b0000, 32'h0,         32'hFFFF_80F1);
    add(1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h1234_5678, 1, 1'b0, 2, 3, 4'b0000, 32'h0,         32'h1234_5678);
    add(1'b1, 3'b010, 32'h0000_0040, 32'h5555_AAAA, 32'h0,       99, 1'b1, 4, 5, 4'b1111, 32'h5555_AAAA, 32'h1234_5678);
    add(1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 4, 5, 4'b0000, 32'h0,         32'hCAFE_F00D);
    add(1'b0, 3'b100, 32'h0000_0002, 32'h0,         32'h80F1_7F02, 0, 1'b0, 1, 2, 4'b0000, 32'h0,         32'h0000_00F1);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst.done", {31'd0, lsu_done}, 32'd0);
    chk("rst.err", {31'd0, lsu_err}, 32'd0);
    chk("rst.rdata", lsu_rdata, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;

    foreach (vq[i]) run_op(vq[i], i);

    // reset while waiting in REQ, with an ack arriving alongside and after reset
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("mid.req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("mid.req_off", {31'd0, mem_req}, 32'd0);
    chk("mid.no_done", {31'd0, lsu_done}, 32'd0);
    chk("mid.state", {30'd0, state_dbg}, 32'd0);
    chk("mid.ready_in_reset", {31'd0, lsu_ready}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid.post_done", {31'd0, lsu_done}, 32'd0);
      chk("mid.post_req", {31'd0, mem_req}, 32'd0);
      chk("mid.post_ready", {31'd0, lsu_ready}, 32'd1);
    end
    chk("mid.rdata", lsu_rdata, 32'd0);
    chk("mid.err", {31'd0, lsu_err}, 32'd0);
    mem_ack = 1'b0;

    // back-to-back: valid held high, second op must wait for IDLE
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010;
    lsu_addr = 32'h300; lsu_wdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.ready_req", {31'd0, lsu_ready}, 32'd0);
    chk("b2b.req1", {31'd0, mem_req}, 32'd1);
    chk("b2b.wdata1", mem_wdata, 32'h1122_3344);
    mem_ack = 1'b1;
    lsu_funct3 = 3'b000; lsu_addr = 32'h301; lsu_wdata = 32'h0000_0077;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.done1", {31'd0, lsu_done}, 32'd1);
    chk("b2b.ready_done", {31'd0, lsu_ready}, 32'd0);
    chk("b2b.req_done", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("b2b.ready_idle", {31'd0, lsu_ready}, 32'd1);
    chk("b2b.req_idle", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("b2b.req2", {31'd0, mem_req}, 32'd1);
    chk("b2b.addr2", mem_addr, 32'h0000_0300);
    chk("b2b.strb2", {28'd0, mem_wstrb}, 32'h2);
    chk("b2b.wdata2", mem_wdata, 32'h7777_7777);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.done2", {31'd0, lsu_done}, 32'd1);
    chk("b2b.err2", {31'd0, lsu_err}, 32'd0);
    @(negedge clk);
    chk("b2b.final_state", {30'd0, state_dbg}, 32'd0);
    chk("b2b.final_req", {31'd0, mem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
